// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/sub_unit.sv
// rtl/sub_unit.sv - combinational subtractor with borrow out
// a_i, b_i   : operands, W bits
// diff_o     : a_i - b_i modulo 2^W
// borrow_o   : 1 when a_i < b_i (unsigned)
module sub_unit #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] full;

    assign full     = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o   = full[W-1:0];
    assign borrow_o = full[W];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 34-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// clk, rst            : clock, synchronous active-high reset
// start, is_signed    : request (taken only when idle), signed mode
// operand_a/operand_b : dividend/divisor, sampled on the accepting edge
// busy, done          : operation in progress, one-cycle result strobe
// quotient/remainder  : registered results, held until the next done
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             diff_msb_unused;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    // The partial remainder stays below the divisor, so it fits in WIDTH bits
    // and the subtractor's top difference bit is always zero when taken.
    assign shifted         = {rem_q, dvd_q[WIDTH-1]};
    assign diff_msb_unused = diff[WIDTH];

    sub_unit #(.W(WIDTH + 1)) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    assign neg_a = is_signed & operand_a[WIDTH-1];
    assign neg_b = is_signed & operand_b[WIDTH-1];
    assign mag_a = neg_a ? -operand_a : operand_a;
    assign mag_b = neg_b ? -operand_b : operand_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        quot_d   = quot_q;
        rmd_d    = rmd_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d    = mag_a;
                    dvs_d    = mag_b;
                    sign_q_d = neg_a ^ neg_b;
                    sign_r_d = neg_a;
                    div0_d   = (operand_b == '0);
                    ovf_d    = is_signed && (operand_a == INT_MIN) && (operand_b == '1);
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Divide-by-zero leaves the natural remainder |a|, which the
                // dividend-sign correction turns back into operand_a.
                if (div0_q) begin
                    quot_d = DIV_BY_ZERO_Q;
                    rmd_d  = sign_r_q ? -rem_q : rem_q;
                end else if (ovf_q) begin
                    quot_d = INT_MIN;
                    rmd_d  = '0;
                end else begin
                    quot_d = sign_q_q ? -dvd_q : dvd_q;
                    rmd_d  = sign_r_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            quot_q   <= quot_d;
            rmd_q    <= rmd_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;

endmodule
